// File: rtl/slim_freeze_ctrl_if.sv
// Ice-shot handshake bus between the shot logic (master) and the slime
// freeze controller (slave). The shot logic holds shot_valid with a stable
// position until it sees the one-cycle shot_consume pulse.
interface slim_freeze_ctrl_if;
    logic       shot_valid;
    logic [9:0] x_shot;
    logic [8:0] y_shot;
    logic       shot_consume;

    modport master (
        output shot_valid,
        output x_shot,
        output y_shot,
        input  shot_consume
    );

    modport slave (
        input  shot_valid,
        input  x_shot,
        input  y_shot,
        output shot_consume
    );
endinterface

// File: rtl/slim_freeze_ctrl.sv
// Slime freeze controller: detects ice-shot hits on the slime, holds the
// freeze for FREEZE_TICKS animation ticks, flags the last WARN_TICKS ticks
// as the thaw-warning window, and reports player/slime contact while the
// slime walks. All outputs are registered.
module slim_freeze_ctrl #(
    parameter int unsigned TICK_VAL     = 6000000,
    parameter int unsigned SLIM_W       = 34,
    parameter int unsigned SLIM_H       = 33,
    parameter int unsigned SHOT_W       = 8,
    parameter int unsigned SHOT_H       = 8,
    parameter int unsigned PLAYER_W     = 32,
    parameter int unsigned PLAYER_H     = 32,
    parameter int unsigned FREEZE_TICKS = 127,
    parameter int unsigned WARN_TICKS   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                i_ipcnt,
    slim_freeze_ctrl_if.slave          shot_bus,
    input  logic [9:0]                 i_x_slim,
    input  logic [8:0]                 i_y_slim,
    input  logic [9:0]                 i_x_player,
    input  logic [8:0]                 i_y_player,
    output logic                       o_slim_frozen,
    output logic                       o_slim_thaw_warn,
    output logic                       o_player_hit,
    output logic [6:0]                 o_freeze_left,
    output logic [7:0]                 o_hit_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FROZEN = 2'd1,
        ST_WARN   = 2'd2
    } state_t;

    localparam logic [31:0] C_TICK_VAL = 32'(TICK_VAL);
    localparam logic [6:0]  C_FREEZE   = 7'(FREEZE_TICKS);
    localparam logic [6:0]  C_WARN     = 7'(WARN_TICKS);

    // Inclusive axis-aligned rectangle overlap. One extra bit on each axis
    // keeps the far-edge sums from wrapping near the screen border.
    function automatic logic f_overlap(
        input logic [10:0] ax, input logic [9:0] ay,
        input logic [10:0] aw, input logic [9:0] ah,
        input logic [10:0] bx, input logic [9:0] by,
        input logic [10:0] bw, input logic [9:0] bh
    );
        logic [10:0] ax1;
        logic [10:0] bx1;
        logic [9:0]  ay1;
        logic [9:0]  by1;
        ax1 = ax + aw - 11'd1;
        bx1 = bx + bw - 11'd1;
        ay1 = ay + ah - 10'd1;
        by1 = by + bh - 10'd1;
        return (ax <= bx1) && (bx <= ax1) && (ay <= by1) && (by <= ay1);
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [6:0]  r_freeze_left;
    logic [6:0]  w_freeze_left_nxt;
    logic [6:0]  w_left_dec;
    logic [7:0]  r_hit_cnt;
    logic [7:0]  w_hit_cnt_nxt;
    logic        r_shot_armed;
    logic        w_shot_armed_nxt;
    logic        r_contact_d;
    logic        r_slim_frozen;
    logic        r_thaw_warn;
    logic        r_shot_consume;
    logic        r_player_hit;

    logic        w_tick;
    logic        w_shot_ovl;
    logic        w_player_ovl;
    logic        w_shot_hit;
    logic        w_contact;

    // The renderer guarantees ipcnt sits on TICK_VAL for exactly one clock,
    // so a plain compare is a single-cycle tick strobe.
    assign w_tick = (i_ipcnt == C_TICK_VAL);

    assign w_shot_ovl = f_overlap(
        {1'b0, shot_bus.x_shot}, {1'b0, shot_bus.y_shot}, 11'(SHOT_W), 10'(SHOT_H),
        {1'b0, i_x_slim},        {1'b0, i_y_slim},        11'(SLIM_W), 10'(SLIM_H));

    assign w_player_ovl = f_overlap(
        {1'b0, i_x_player}, {1'b0, i_y_player}, 11'(PLAYER_W), 10'(PLAYER_H),
        {1'b0, i_x_slim},   {1'b0, i_y_slim},   11'(SLIM_W),   10'(SLIM_H));

    // A shot counts once: arming is cleared on the hit and only restored
    // after the shot logic has dropped shot_valid.
    assign w_shot_hit = shot_bus.shot_valid & r_shot_armed & w_shot_ovl;

    // A frozen slime is harmless, so contact only exists while walking.
    assign w_contact  = w_player_ovl & (r_state == ST_IDLE);

    assign w_left_dec = r_freeze_left - 7'd1;

    // Next-state, freeze countdown, hit counter and shot re-arm logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_nxt       = r_state;
        w_freeze_left_nxt = r_freeze_left;
        w_hit_cnt_nxt     = r_hit_cnt;
        w_shot_armed_nxt  = r_shot_armed;

        if (w_shot_hit) begin
            w_shot_armed_nxt = 1'b0;
        end else if (!shot_bus.shot_valid) begin
            w_shot_armed_nxt = 1'b1;
        end

        if (w_shot_hit) begin
            // A hit (fresh or re-freeze) wins over a coincident tick.
            w_state_nxt       = ST_FROZEN;
            w_freeze_left_nxt = C_FREEZE;
            if (r_hit_cnt != 8'hFF) begin
                w_hit_cnt_nxt = r_hit_cnt + 8'd1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_freeze_left_nxt = 7'd0;
                end
                ST_FROZEN: begin
                    if (w_tick) begin
                        w_freeze_left_nxt = w_left_dec;
                        if (w_left_dec == 7'd0) begin
                            w_state_nxt = ST_IDLE;
                        end else if (w_left_dec == C_WARN) begin
                            w_state_nxt = ST_WARN;
                        end
                    end
                end
                ST_WARN: begin
                    if (w_tick) begin
                        if (r_freeze_left == 7'd1) begin
                            w_state_nxt       = ST_IDLE;
                            w_freeze_left_nxt = 7'd0;
                        end else begin
                            w_freeze_left_nxt = w_left_dec;
                        end
                    end
                end
                default: begin
                    w_state_nxt       = ST_IDLE;
                    w_freeze_left_nxt = 7'd0;
                end
            endcase
        end
    end

    // State register and registered outputs, decoded from the next state so
    // the renderer sees the freeze one cycle after the hit cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_freeze_left  <= 7'd0;
            r_hit_cnt      <= 8'd0;
            r_shot_armed   <= 1'b1;
            r_contact_d    <= 1'b0;
            r_slim_frozen  <= 1'b0;
            r_thaw_warn    <= 1'b0;
            r_shot_consume <= 1'b0;
            r_player_hit   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state        <= w_state_nxt;
            r_freeze_left  <= w_freeze_left_nxt;
            r_hit_cnt      <= w_hit_cnt_nxt;
            r_shot_armed   <= w_shot_armed_nxt;
            r_contact_d    <= w_contact;
            r_slim_frozen  <= (w_state_nxt != ST_IDLE);
            r_thaw_warn    <= (w_state_nxt == ST_WARN);
            r_shot_consume <= w_shot_hit;
            r_player_hit   <= w_contact & ~r_contact_d;
        end
    end

    assign shot_bus.shot_consume = r_shot_consume;
    assign o_slim_frozen         = r_slim_frozen;
    assign o_slim_thaw_warn      = r_thaw_warn;
    assign o_player_hit          = r_player_hit;
    assign o_freeze_left         = r_freeze_left;
    assign o_hit_cnt             = r_hit_cnt;

endmodule

// File: tb/tb_slim_freeze_ctrl.sv
// Testbench for slim_freeze_ctrl: directed sequences for the freeze timing,
// hitbox edges, re-freeze/tick collision, contact, reset and saturation,
// then randomized traffic compared against a remaining-ticks model.
module tb_slim_freeze_ctrl;

    localparam int TICK_VAL     = 6000000;
    localparam int SLIM_W       = 34;
    localparam int SLIM_H       = 33;
    localparam int SHOT_W       = 8;
    localparam int SHOT_H       = 8;
    localparam int PLAYER_W     = 32;
    localparam int PLAYER_H     = 32;
    localparam int FREEZE_TICKS = 127;
    localparam int WARN_TICKS   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ipcnt;
    logic [9:0]  x_slim;
    logic [8:0]  y_slim;
    logic [9:0]  x_player;
    logic [8:0]  y_player;
    logic        slim_frozen;
    logic        slim_thaw_warn;
    logic        player_hit;
    logic [6:0]  freeze_left;
    logic [7:0]  hit_cnt;

    slim_freeze_ctrl_if bus ();

    always #5 clk = ~clk;

    slim_freeze_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .i_ipcnt          (ipcnt),
        .shot_bus         (bus),
        .i_x_slim         (x_slim),
        .i_y_slim         (y_slim),
        .i_x_player       (x_player),
        .i_y_player       (y_player),
        .o_slim_frozen    (slim_frozen),
        .o_slim_thaw_warn (slim_thaw_warn),
        .o_player_hit     (player_hit),
        .o_freeze_left    (freeze_left),
        .o_hit_cnt        (hit_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the whole freeze is one remaining-ticks number.
    // Frozen while it is non-zero, warning while it is in 1..WARN_TICKS.
    int m_left;
    int m_hits;
    bit m_armed;
    bit m_cprev;
    bit m_consume;
    bit m_phit;

    typedef struct {
        logic [9:0] xs;
        logic [8:0] ys;
        bit         exp_hit;
    } edge_vec_t;

    edge_vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ov(input int ax, input int ay, input int aw, input int ah,
                              input int bx, input int by, input int bw, input int bh);
        return (ax <= bx + bw - 1) && (bx <= ax + aw - 1) &&
               (ay <= by + bh - 1) && (by <= ay + ah - 1);
    endfunction

    // One clock: advance the model on the pre-edge inputs, then compare
    // every output 1 time unit after the edge.
    task automatic cycle();
        bit hit;
        bit contact;
        bit tick;
        if (rst) begin
            m_left = 0; m_hits = 0; m_armed = 1; m_cprev = 0;
            m_consume = 0; m_phit = 0;
        end else begin
            tick    = (ipcnt == TICK_VAL);
            hit     = bus.shot_valid && m_armed &&
                      ov(bus.x_shot, bus.y_shot, SHOT_W, SHOT_H, x_slim, y_slim, SLIM_W, SLIM_H);
            contact = (m_left == 0) &&
                      ov(x_player, y_player, PLAYER_W, PLAYER_H, x_slim, y_slim, SLIM_W, SLIM_H);
            m_consume = hit;
            m_phit    = contact && !m_cprev;
            m_cprev   = contact;
            if (hit) begin
                m_left = FREEZE_TICKS;
                if (m_hits < 255) m_hits++;
            end else if (tick && m_left > 0) begin
                m_left--;
            end
            if (hit) m_armed = 0;
            else if (!bus.shot_valid) m_armed = 1;
        end
        @(posedge clk);
        #1;
        check("model_consume", bus.shot_consume, m_consume);
        check("model_player_hit", player_hit, m_phit);
        check("model_frozen", slim_frozen, m_left != 0);
        check("model_warn", slim_thaw_warn, (m_left != 0) && (m_left <= WARN_TICKS));
        check("model_freeze_left", freeze_left, m_left);
        check("model_hit_cnt", hit_cnt, m_hits);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    // n ticks, each followed by a non-tick cycle.
    task automatic tick_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            ipcnt = TICK_VAL;
            cycle();
            ipcnt = 32'd0;
            cycle();
        end
    endtask

    // One clean hit on the standard slime position, then release the shot.
    task automatic shoot_once();
        bus.x_shot     = 10'd310;
        bus.y_shot     = 9'd370;
        bus.shot_valid = 1'b1;
        cycle();
        bus.shot_valid = 1'b0;
        cycle();
    endtask

    initial begin
        int cnt;

        vecs[0] = '{10'd333, 9'd370, 1'b1};
        vecs[1] = '{10'd334, 9'd370, 1'b0};
        vecs[2] = '{10'd292, 9'd370, 1'b0};
        vecs[3] = '{10'd293, 9'd370, 1'b1};
        vecs[4] = '{10'd310, 9'd399, 1'b1};
        vecs[5] = '{10'd310, 9'd400, 1'b0};
        vecs[6] = '{10'd310, 9'd359, 1'b0};
        vecs[7] = '{10'd310, 9'd360, 1'b1};
        vecs[8] = '{10'd334, 9'd400, 1'b0};
        vecs[9] = '{10'd293, 9'd360, 1'b1};

        rst            = 1'b1;
        ipcnt          = 32'd0;
        x_slim         = 10'd300;
        y_slim         = 9'd367;
        x_player       = 10'd700;
        y_player       = 9'd100;
        bus.shot_valid = 1'b0;
        bus.x_shot     = 10'd0;
        bus.y_shot     = 9'd0;

        // Reset state
        do_reset(2);
        cycle();
        check("rst_frozen", slim_frozen, 0);
        check("rst_freeze_left", freeze_left, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_consume", bus.shot_consume, 0);

        // Freeze timing
        bus.x_shot     = 10'd310;
        bus.y_shot     = 9'd370;
        bus.shot_valid = 1'b1;
        cycle();
        check("frz_consume", bus.shot_consume, 1);
        check("frz_frozen", slim_frozen, 1);
        check("frz_left", freeze_left, 127);
        check("frz_hit_cnt", hit_cnt, 1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("frz_no_second_consume", bus.shot_consume, 0);
        end
        bus.shot_valid = 1'b0;
        cycle();
        tick_cycles(110);
        check("frz_left_110", freeze_left, 17);
        check("frz_warn_110", slim_thaw_warn, 0);
        tick_cycles(1);
        check("frz_left_111", freeze_left, 16);
        check("frz_warn_111", slim_thaw_warn, 1);
        check("frz_frozen_111", slim_frozen, 1);
        tick_cycles(16);
        check("thaw_frozen", slim_frozen, 0);
        check("thaw_left", freeze_left, 0);
        check("thaw_warn", slim_thaw_warn, 0);

        // Hitbox edges, table-driven
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            bus.x_shot     = vecs[i].xs;
            bus.y_shot     = vecs[i].ys;
            bus.shot_valid = 1'b1;
            cycle();
            check($sformatf("edge_consume_%0d", i), bus.shot_consume, vecs[i].exp_hit);
            bus.shot_valid = 1'b0;
            cycle();
        end

        // Re-freeze colliding with a tick in WARN
        do_reset(1);
        shoot_once();
        tick_cycles(122);
        check("rf_left_5", freeze_left, 5);
        check("rf_warn_5", slim_thaw_warn, 1);
        bus.shot_valid = 1'b1;
        ipcnt          = TICK_VAL;
        cycle();
        check("rf_left", freeze_left, 127);
        check("rf_warn", slim_thaw_warn, 0);
        check("rf_frozen", slim_frozen, 1);
        check("rf_hit_cnt", hit_cnt, 2);
        check("rf_consume", bus.shot_consume, 1);
        bus.shot_valid = 1'b0;
        ipcnt          = 32'd0;
        cycle();

        // Contact with a walking slime, then through a freeze
        do_reset(1);
        x_player = 10'd310;
        y_player = 9'd370;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            cnt += int'(player_hit);
        end
        check("contact_walk_pulses", cnt, 1);
        shoot_once();
        cnt = int'(player_hit);
        for (int i = 0; i < FREEZE_TICKS; i++) begin
            ipcnt = TICK_VAL;
            cycle();
            cnt += int'(player_hit);
            ipcnt = 32'd0;
            if (i != FREEZE_TICKS - 1) begin
                cycle();
                cnt += int'(player_hit);
            end
        end
        check("contact_frozen_pulses", cnt, 0);
        check("contact_thawed", slim_frozen, 0);
        cycle();
        check("contact_after_thaw", player_hit, 1);
        cycle();
        check("contact_after_thaw_once", player_hit, 0);
        x_player = 10'd700;
        y_player = 9'd100;

        // Reset mid-freeze
        do_reset(1);
        shoot_once();
        tick_cycles(77);
        check("mr_left_50", freeze_left, 50);
        rst = 1'b1;
        cycle();
        check("mr_frozen_after_edge", slim_frozen, 0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("mr_frozen", slim_frozen, 0);
        check("mr_left", freeze_left, 0);
        check("mr_hit_cnt", hit_cnt, 0);
        check("mr_warn", slim_thaw_warn, 0);

        // Hit counter saturation
        do_reset(1);
        for (int i = 0; i < 260; i++) shoot_once();
        check("sat_hit_cnt", hit_cnt, 255);

        // Randomized traffic against the model
        do_reset(1);
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 15) == 0) begin
                x_slim = 10'($urandom);
                y_slim = 9'($urandom);
                bus.x_shot = 10'($urandom);
                bus.y_shot = 9'($urandom);
            end else if ($urandom_range(0, 31) == 0 || i == 0) begin
                x_slim = 10'($urandom_range(100, 900));
                y_slim = 9'($urandom_range(50, 450));
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.x_shot = 10'(int'(x_slim) - 40 + int'($urandom_range(0, 80)));
                bus.y_shot = 9'(int'(y_slim) - 40 + int'($urandom_range(0, 80)));
            end
            if ($urandom_range(0, 7) == 0) begin
                x_player = 10'(int'(x_slim) - 50 + int'($urandom_range(0, 100)));
                y_player = 9'(int'(y_slim) - 50 + int'($urandom_range(0, 100)));
            end
            bus.shot_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0, 1:    ipcnt = TICK_VAL;
                2:       ipcnt = TICK_VAL - 1;
                3:       ipcnt = TICK_VAL + 1;
                default: ipcnt = $urandom;
            endcase
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
